// File: rtl/bram_byte_access_master_if.sv
// LSU request/response channel plus the byte-enabled BRAM port, bundled for one
// bram_byte_access_master instance (master) and its environment (slave).
interface bram_byte_access_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [1:0]              req_size;
    logic                    req_unsigned;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_error;
    logic                    mem_readEnable;
    logic                    mem_writeEnable;
    logic [3:0]              mem_writeByteEnable;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_writeData;
    logic [DATA_WIDTH-1:0]   mem_readData;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_error,
        input  resp_ready,
        output mem_readEnable, mem_writeEnable, mem_writeByteEnable, mem_address, mem_writeData,
        input  mem_readData
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_error,
        output resp_ready,
        input  mem_readEnable, mem_writeEnable, mem_writeByteEnable, mem_address, mem_writeData,
        output mem_readData
    );
endinterface

// File: rtl/bram_byte_access_master.sv
// Single-outstanding LSU load/store master for one byte-enabled BRAM port.
// Optional BRAM_MISALIGN_TRAP_EN: misaligned half/word accesses return resp_error instead of aligning.
module bram_byte_access_master #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,  // only 32 is supported
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    bram_byte_access_master_if.master   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state;
    logic            write_p0;
    logic [1:0]      size_p0;
    logic            uns_p0;
    logic [1:0]      off_p0;
    logic            req_err;
    logic [31:0]     unused_core;

    assign unused_core = 32'(CORE);

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                         input logic [DATA_WIDTH-1:0] w);
        case (size)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [1:0] size, input logic uns,
                                                          input logic [1:0] off,
                                                          input logic [DATA_WIDTH-1:0] rd);
        logic [DATA_WIDTH-1:0]        sh;
        logic signed [7:0]            b;
        logic signed [15:0]           h;
        logic signed [DATA_WIDTH-1:0] ext;
        sh  = rd;
        ext = rd;
        case (size)
            2'b00: begin
                sh  = rd >> {off, 3'b000};
                b   = sh[7:0];
                ext = b;
                if (uns) ext = {24'd0, sh[7:0]};
            end
            2'b01: begin
                sh  = rd >> {off[1], 4'b0000};
                h   = sh[15:0];
                ext = h;
                if (uns) ext = {16'd0, sh[15:0]};
            end
            default: ext = rd;
        endcase
        return ext;
    endfunction

    always_comb begin
        req_err = (bus.req_size == 2'b11);
`ifdef BRAM_MISALIGN_TRAP_EN
        if (bus.req_size == 2'b01 && bus.req_addr[0])          req_err = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            bus.req_ready           <= 1'b0;
            bus.mem_readEnable      <= 1'b0;
            bus.mem_writeEnable     <= 1'b0;
            bus.mem_writeByteEnable <= 4'b0000;
            bus.mem_address         <= '0;
            bus.mem_writeData       <= '0;
            bus.resp_valid          <= 1'b0;
            bus.resp_rdata          <= '0;
            bus.resp_error          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        write_p0      <= bus.req_write;
                        size_p0       <= bus.req_size;
                        uns_p0        <= bus.req_unsigned;
                        off_p0        <= bus.req_addr[1:0];
                        if (req_err) begin
                            // Rejected requests never touch the BRAM
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            state                   <= ACCESS;
                            bus.mem_address         <= bus.req_addr[ADDR_WIDTH+1:2];
                            bus.mem_readEnable      <= !bus.req_write;
                            bus.mem_writeEnable     <= bus.req_write;
                            bus.mem_writeByteEnable <= bus.req_write ?
                                byte_enable(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
                            bus.mem_writeData       <= lane_wdata(bus.req_size, bus.req_wdata);
                        end
                    end
                end
                // ---- ACCESS: strobes visible to the BRAM for exactly this cycle
                ACCESS: begin
                    bus.mem_readEnable      <= 1'b0;
                    bus.mem_writeEnable     <= 1'b0;
                    bus.mem_writeByteEnable <= 4'b0000;
                    if (write_p0) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b0;
                        bus.resp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                // ---- WAIT: BRAM read data valid, align and extend into the response
                WAIT: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_error <= 1'b0;
                    bus.resp_rdata <= load_extend(size_p0, uns_p0, off_p0, bus.mem_readData);
                end
                // ---- RESP: hold until the consumer takes it
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_byte_access_master.sv
// Directed-vector bench for bram_byte_access_master with a BRAM model and a response scoreboard.
module tb_bram_byte_access_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [256];
    logic        prev_v = 1'b0;

    bram_byte_access_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    bram_byte_access_master #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous BRAM: byte-enabled write, one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_writeEnable)
            for (int i = 0; i < 4; i++)
                if (bus.mem_writeByteEnable[i])
                    mem[bus.mem_address][8*i +: 8] <= bus.mem_writeData[8*i +: 8];
        if (bus.mem_readEnable) bus.mem_readData <= mem[bus.mem_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.resp_valid && !prev_v) begin
                if (exp_q.size() == 0) chk("resp_valid_unexpected", 32'(bus.resp_valid), 32'd0);
                else                   chk("resp_latency", 32'(cyc), 32'(exp_q[0].cyc));
            end
            if (bus.resp_valid && bus.resp_ready && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rd);
                chk("resp_error", 32'(bus.resp_error), 32'(e.err));
            end
            prev_v = bus.resp_valid;
        end
    end

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Issue one request; returns at the negedge of the cycle after acceptance
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [9:0] addr, input logic [31:0] wd,
                          input logic expect_resp, input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input logic exp_acc, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [7:0] exp_ma,
                          input logic wait_done);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        if (expect_resp) exp_q.push_back('{exp_rd, exp_err, cyc + lat});
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (exp_acc) begin
            chk("mem_writeEnable", 32'(bus.mem_writeEnable), 32'(wr));
            chk("mem_readEnable", 32'(bus.mem_readEnable), 32'(!wr));
            chk("mem_writeByteEnable", 32'(bus.mem_writeByteEnable), 32'(exp_be));
            chk("mem_address", 32'(bus.mem_address), 32'(exp_ma));
            if (wr) chk("mem_writeData", bus.mem_writeData, exp_wd);
        end else begin
            chk("no_mem_strobe", 32'({bus.mem_readEnable, bus.mem_writeEnable,
                                      bus.mem_writeByteEnable}), 32'd0);
        end
        if (wait_done) wait_empty();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5A5A5;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_strobes", 32'({bus.mem_readEnable, bus.mem_writeEnable,
                                    bus.mem_writeByteEnable}), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // SW 0xDEADBEEF @0x10, LW @0x10
        do_req(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 1, 32'h0, 0, 2, 1, 4'hF, 32'hDEADBEEF, 8'd4, 1);
        do_req(0, 2'b10, 0, 10'h010, 32'h0, 1, 32'hDEADBEEF, 0, 3, 1, 4'h0, 32'h0, 8'd4, 1);
        // SB 0x80 @0x13, LB / LBU @0x13
        do_req(1, 2'b00, 0, 10'h013, 32'h00000080, 1, 32'h0, 0, 2, 1, 4'b1000, 32'h80808080, 8'd4, 1);
        do_req(0, 2'b00, 0, 10'h013, 32'h0, 1, 32'hFFFFFF80, 0, 3, 1, 4'h0, 32'h0, 8'd4, 1);
        do_req(0, 2'b00, 1, 10'h013, 32'h0, 1, 32'h00000080, 0, 3, 1, 4'h0, 32'h0, 8'd4, 1);
        // LB @0x11 (0xBE sign-extended), LHU @0x12 (0x80AD)
        do_req(0, 2'b00, 0, 10'h011, 32'h0, 1, 32'hFFFFFFBE, 0, 3, 1, 4'h0, 32'h0, 8'd4, 1);
        do_req(0, 2'b01, 1, 10'h012, 32'h0, 1, 32'h000080AD, 0, 3, 1, 4'h0, 32'h0, 8'd4, 1);
        // SH 0x1234 @0x16, LH @0x16, LW @0x14 shows untouched low lanes
        do_req(1, 2'b01, 0, 10'h016, 32'h00001234, 1, 32'h0, 0, 2, 1, 4'b1100, 32'h12341234, 8'd5, 1);
        do_req(0, 2'b01, 0, 10'h016, 32'h0, 1, 32'h00001234, 0, 3, 1, 4'h0, 32'h0, 8'd5, 1);
        do_req(0, 2'b10, 0, 10'h014, 32'h0, 1, 32'h1234A5A5, 0, 3, 1, 4'h0, 32'h0, 8'd5, 1);
        // Reserved size
        do_req(0, 2'b11, 0, 10'h010, 32'h0, 1, 32'h0, 1, 1, 0, 4'h0, 32'h0, 8'd0, 1);
        do_req(1, 2'b11, 0, 10'h020, 32'hFFFFFFFF, 1, 32'h0, 1, 1, 0, 4'h0, 32'h0, 8'd0, 1);
        chk("reserved_store_no_write", mem[8], 32'hA5A5A5A5);
        // Misaligned LH @0x11
`ifdef BRAM_MISALIGN_TRAP_EN
        do_req(0, 2'b01, 0, 10'h011, 32'h0, 1, 32'h0, 1, 1, 0, 4'h0, 32'h0, 8'd0, 1);
`else
        do_req(0, 2'b01, 0, 10'h011, 32'h0, 1, 32'hFFFFBEEF, 0, 3, 1, 4'h0, 32'h0, 8'd4, 1);
`endif

        // Response back-pressure: LW @0x10 held for 5 cycles
        bus.resp_ready = 1'b0;
        do_req(0, 2'b10, 0, 10'h010, 32'h0, 1, 32'h80ADBEEF, 0, 3, 1, 4'h0, 32'h0, 8'd4, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("stall_resp_rdata", bus.resp_rdata, 32'h80ADBEEF);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        wait_empty();

        // Reset while in WAIT abandons the load
        do_req(0, 2'b10, 0, 10'h010, 32'h0, 0, 32'h0, 0, 3, 1, 4'h0, 32'h0, 8'd4, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wait_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("wait_rst_req_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        chk("wait_rst_req_ready_back", 32'(bus.req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
